// File: rtl/lsharp_pkg.sv
// Shared definitions for the LSharp core: 16-bit register one-hot indices,
// fetch state encoding and the CB prefix opcode.
package lsharp_pkg;

  localparam int REG_WZ = 0;
  localparam int REG_BC = 1;
  localparam int REG_DE = 2;
  localparam int REG_HL = 3;
  localparam int REG_SP = 4;
  localparam int REG_PC = 5;

  localparam logic [7:0] CB_PREFIX = 8'hCB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_READ,
    ST_VALID
  } fetch_state_e;

endpackage

// File: rtl/lsharp_idu.sv
// 16-bit increment unit; wraps 16'hFFFF to 16'h0000.
module lsharp_idu (
  input  logic [15:0] value,
  output logic [15:0] result
);

  assign result = value + 16'd1;

endmodule

// File: rtl/lsharp_fetch_unit.sv
// Opcode fetch unit: reads PC, fetches one byte, writes PC+1, hands the opcode
// to the decoder. Define LSHARP_CB_PREFIX_EN to fetch CB-prefixed opcodes as one unit.
module lsharp_fetch_unit #(
  parameter int         PC_SEL    = lsharp_pkg::REG_PC,
  parameter logic [7:0] CB_PREFIX = lsharp_pkg::CB_PREFIX
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Enable,
  input  logic        i_Fetch_En,
  output logic [7:0]  o_Read16,
  output logic [7:0]  o_Write16,
  output logic [15:0] o_Bus16,
  input  logic [15:0] i_Bus16,
  output logic [15:0] o_Mem_Addr,
  output logic        o_Mem_Rd,
  input  logic [7:0]  i_Mem_Data,
  input  logic        i_Mem_Wait,
  output logic [7:0]  o_Opcode,
  output logic        o_Op_CB,
  output logic        o_Op_Valid,
  input  logic        i_Op_Ready,
  output logic        o_Busy
);

  import lsharp_pkg::*;

  localparam logic [7:0] PC_MASK = 8'b0000_0001 << PC_SEL;

  fetch_state_e state;
  logic [15:0]  addr;
  logic [15:0]  pc_next;
  logic [7:0]   opcode;
  logic         cb_flag;
  logic         read_done;

`ifdef LSHARP_CB_PREFIX_EN
  localparam bit CB_EN = 1'b1;
  assign o_Op_CB = cb_flag;
`else
  localparam bit CB_EN = 1'b0;
  assign o_Op_CB = 1'b0;
`endif

  lsharp_idu u_idu (
    .value  (addr),
    .result (pc_next)
  );

  // A read completes only on an enabled, unstalled READ cycle; this gates the PC write.
  assign read_done = (state == ST_READ) && i_Enable && !i_Mem_Wait;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    // NOTE: non-blocking assignments keep every register update in this block
    // reading the pre-edge values, so statement order cannot change behaviour.
    if (i_Reset) begin
      state   <= ST_IDLE;
      addr    <= '0;
      opcode  <= '0;
      cb_flag <= 1'b0;
    end else if (i_Enable) begin
      case (state)
        ST_IDLE: begin
          if (i_Fetch_En) state <= ST_ADDR;
        end
        ST_ADDR: begin
          addr  <= i_Bus16;
          state <= ST_READ;
        end
        ST_READ: begin
          if (!i_Mem_Wait) begin
            opcode <= i_Mem_Data;
            if (CB_EN && !cb_flag && (i_Mem_Data == CB_PREFIX)) begin
              cb_flag <= 1'b1;
              state   <= ST_ADDR;
            end else begin
              state <= ST_VALID;
            end
          end
        end
        ST_VALID: begin
          if (i_Op_Ready) begin
            cb_flag <= 1'b0;
            state   <= i_Fetch_En ? ST_ADDR : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_Read16   = (state == ST_ADDR) ? PC_MASK : 8'h00;
  assign o_Write16  = read_done ? PC_MASK : 8'h00;
  assign o_Bus16    = (state == ST_READ) ? pc_next : 16'h0000;
  assign o_Mem_Addr = addr;
  assign o_Mem_Rd   = (state == ST_READ) && i_Enable;
  assign o_Opcode   = opcode;
  assign o_Op_Valid = (state == ST_VALID);
  assign o_Busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_lsharp_fetch_unit.sv
// Directed bench for lsharp_fetch_unit: table of single fetches plus hand-written
// back-to-back, enable-freeze and mid-READ reset sequences. Honours LSHARP_CB_PREFIX_EN.
module tb_lsharp_fetch_unit;

  localparam logic [7:0] PC_MASK = 8'h20;

  logic        clk = 1'b0;
  logic        rst, enable, fetch_en, mem_wait, op_ready;
  logic [7:0]  read16, write16, opcode, mem_data;
  logic [15:0] bus16_out, bus16_in, mem_addr;
  logic        mem_rd, op_cb, op_valid, busy;

  logic [15:0] pc, pc_init;
  logic        pc_load;
  int          wr_count = 0;
  int          viol = 0;
  int          checks = 0;
  int          errors = 0;
  int          waits_left = 0;

  typedef struct {
    logic [15:0] pc;
    int          waits;
    int          hold;
    logic [7:0]  exp_op;
    logic        exp_cb;
    logic [15:0] exp_pc;
    int          exp_cyc;
    int          exp_writes;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  lsharp_fetch_unit dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_Enable   (enable),
    .i_Fetch_En (fetch_en),
    .o_Read16   (read16),
    .o_Write16  (write16),
    .o_Bus16    (bus16_out),
    .i_Bus16    (bus16_in),
    .o_Mem_Addr (mem_addr),
    .o_Mem_Rd   (mem_rd),
    .i_Mem_Data (mem_data),
    .i_Mem_Wait (mem_wait),
    .o_Opcode   (opcode),
    .o_Op_CB    (op_cb),
    .o_Op_Valid (op_valid),
    .i_Op_Ready (op_ready),
    .o_Busy     (busy)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0100: return 8'h3E;
      16'h0101: return 8'h11;
      16'hFFFF: return 8'h00;
      16'h0200: return 8'hCB;
      16'h0201: return 8'h37;
      16'h0300: return 8'h77;
      16'h1234: return 8'hA5;
      16'h0400: return 8'h66;
      16'h0500: return 8'hA1;
      default:  return a[7:0] ^ a[15:8];
    endcase
  endfunction

  assign mem_data = mem_byte(mem_addr);
  assign bus16_in = read16[5] ? pc : 16'hDEAD;

  // Register-file model for PC plus strobe rule monitor.
  always @(posedge clk) begin
    if (pc_load) pc <= pc_init;
    else if (write16[5]) pc <= bus16_out;
    if (write16 != 8'h00) begin
      wr_count++;
      if ((write16 & ~PC_MASK) != 8'h00) viol++;
      if (read16 != 8'h00) viol++;
      if (!enable) viol++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_pc(input logic [15:0] v);
    @(negedge clk);
    pc_init = v;
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  // Advance until o_Op_Valid; drives mem_wait for waits_left READ cycles and
  // counts READ cycles whose address differs from the current PC.
  task automatic wait_valid(output int cyc, output int addr_bad);
    cyc = 0;
    addr_bad = 0;
    while (!op_valid && cyc < 40) begin
      step();
      cyc++;
      fetch_en = 1'b0;
      if (mem_rd && mem_addr !== pc) addr_bad++;
      mem_wait = mem_rd && (waits_left > 0);
      if (mem_wait) waits_left--;
    end
    mem_wait = 1'b0;
  endtask

  task automatic run_fetch(input int idx);
    vec_t v;
    int cyc, addr_bad, hold_bad, w0;
    v = vecs[idx];
    set_pc(v.pc);
    w0 = wr_count;
    fetch_en = 1'b1;
    op_ready = 1'b0;
    waits_left = v.waits;
    wait_valid(cyc, addr_bad);
    check($sformatf("v%0d_valid_cycle", idx), cyc, v.exp_cyc);
    check($sformatf("v%0d_addr", idx), addr_bad, 0);
    check($sformatf("v%0d_opcode", idx), opcode, v.exp_op);
    check($sformatf("v%0d_cb", idx), op_cb, v.exp_cb);
    hold_bad = 0;
    for (int i = 0; i < v.hold; i++) begin
      step();
      if (!op_valid || opcode !== v.exp_op || mem_rd) hold_bad++;
    end
    check($sformatf("v%0d_hold", idx), hold_bad, 0);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    check($sformatf("v%0d_idle", idx), {op_valid, busy}, 2'b00);
    check($sformatf("v%0d_pc", idx), pc, v.exp_pc);
    check($sformatf("v%0d_writes", idx), wr_count - w0, v.exp_writes);
  endtask

  initial begin
    int cyc, addr_bad, w0, hold_bad;

    vecs[0] = '{16'h0100, 0, 0, 8'h3E, 1'b0, 16'h0101, 3, 1};
    vecs[1] = '{16'hFFFF, 0, 0, 8'h00, 1'b0, 16'h0000, 3, 1};
    vecs[2] = '{16'h0300, 4, 5, 8'h77, 1'b0, 16'h0301, 7, 1};
    vecs[3] = '{16'h1234, 1, 2, 8'hA5, 1'b0, 16'h1235, 4, 1};
`ifdef LSHARP_CB_PREFIX_EN
    vecs[4] = '{16'h0200, 0, 1, 8'h37, 1'b1, 16'h0202, 5, 2};
`else
    vecs[4] = '{16'h0200, 0, 1, 8'hCB, 1'b0, 16'h0201, 3, 1};
`endif

    rst = 1'b1; enable = 1'b1; fetch_en = 1'b0; mem_wait = 1'b0;
    op_ready = 1'b0; pc_load = 1'b0; pc_init = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {read16, write16, bus16_out, mem_addr, mem_rd, opcode, op_cb, op_valid, busy}, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_fetch(i);

    // Back-to-back fetch: ready with fetch_en goes straight to ADDR.
    set_pc(16'h0100);
    fetch_en = 1'b1;
    waits_left = 0;
    wait_valid(cyc, addr_bad);
    check("b2b_first_cycle", cyc, 3);
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!op_valid || opcode !== 8'h3E || mem_rd) hold_bad++;
    end
    check("b2b_hold", hold_bad, 0);
    op_ready = 1'b1;
    fetch_en = 1'b1;
    step();
    op_ready = 1'b0;
    fetch_en = 1'b0;
    check("b2b_addr_next", read16, PC_MASK);
    wait_valid(cyc, addr_bad);
    check("b2b_period", cyc + 1, 3);
    check("b2b_opcode", opcode, 8'h11);
    check("b2b_pc", pc, 16'h0102);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    check("b2b_idle", busy, 1'b0);

    // Enable low freezes READ and blocks the handshake.
    set_pc(16'h0500);
    w0 = wr_count;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    step();
    enable = 1'b0;
    #1;
    check("en_low_strobes", {mem_rd, write16}, 9'h000);
    repeat (3) step();
    check("en_low_hold", {busy, read16, mem_rd, op_valid}, {1'b1, 8'h00, 1'b0, 1'b0});
    enable = 1'b1;
    #1;
    check("en_resume_write", {write16, bus16_out}, {PC_MASK, 16'h0501});
    step();
    check("en_valid", {op_valid, opcode}, {1'b1, 8'hA1});
    enable = 1'b0;
    op_ready = 1'b1;
    step();
    check("en_low_no_handshake", {op_valid, opcode}, {1'b1, 8'hA1});
    enable = 1'b1;
    step();
    op_ready = 1'b0;
    check("en_handshake", busy, 1'b0);
    check("en_writes", wr_count - w0, 1);

    // Reset asserted during an unstalled READ: no PC write, outputs cleared at once.
    set_pc(16'h0400);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    step();
    check("rst_in_read", mem_rd, 1'b1);
    w0 = wr_count;
    rst = 1'b1;
    #1;
    check("rst_mid_read_outs",
          {read16, write16, bus16_out, mem_addr, mem_rd, opcode, op_cb, op_valid, busy}, '0);
    step();
    check("rst_no_write", wr_count - w0, 0);
    check("rst_pc_kept", pc, 16'h0400);
    rst = 1'b0;
    repeat (3) step();
    check("rst_no_autostart", busy, 1'b0);

    check("strobe_rules", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsharp_fetch_unit.md
LSHARP_FETCH_UNIT -- requirements
Module: lsharp_fetch_unit

Interface
REQ-001 SHALL have parameter PC_SEL, default 5, meaning the bit index of PC in the one-hot 16-bit register select.
REQ-002 SHALL have parameter CB_PREFIX, default 8'hCB, meaning the prefix opcode value.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, exactly as decided.
REQ-004 i_Clk  in  1  system clock; all state changes on its rising edge.
REQ-005 i_Reset  in  1  asynchronous active-high reset.
REQ-006 i_Enable  in  1  system tick; when low, state is frozen.
REQ-007 i_Fetch_En  in  1  permission to start a new opcode fetch.
REQ-008 o_Read16  out  8  one-hot 16-bit read select to the register file.
REQ-009 o_Write16  out  8  one-hot 16-bit write strobe to the register file.
REQ-010 o_Bus16  out  16  write value to the register file (PC+1).
REQ-011 i_Bus16  in  16  read value from the register file.
REQ-012 o_Mem_Addr  out  16  memory address.
REQ-013 o_Mem_Rd  out  1  memory read strobe.
REQ-014 i_Mem_Data  in  8  memory read data.
REQ-015 i_Mem_Wait  in  1  memory stall.
REQ-016 o_Opcode  out  8  fetched opcode (second byte when o_Op_CB=1).
REQ-017 o_Op_CB  out  1  opcode is CB-prefixed.
REQ-018 o_Op_Valid  out  1  opcode available.
REQ-019 i_Op_Ready  in  1  decoder accepts the opcode.
REQ-020 o_Busy  out  1  state is not IDLE.

Function
REQ-021 SHALL implement states IDLE, ADDR, READ and VALID.
REQ-022 IDLE: SHALL go to ADDR when i_Fetch_En=1; otherwise SHALL stay in IDLE.
REQ-023 ADDR: SHALL drive o_Read16=1<<PC_SEL, latch i_Bus16 into an address register, and go to READ.
REQ-024 READ: SHALL drive o_Mem_Rd=1 and o_Mem_Addr=latched address; SHALL stay in READ while i_Mem_Wait=1 with the address held stable.
REQ-025 READ completion (i_Mem_Wait=0): SHALL pulse o_Write16=1<<PC_SEL with o_Bus16=address+1 for exactly that one cycle, and SHALL latch i_Mem_Data.
REQ-026 The increment SHALL be modulo 2^16, so 16'hFFFF becomes 16'h0000.
REQ-027 After READ completion, the block SHALL go to VALID, except as modified by REQ-041.
REQ-028 VALID: SHALL hold o_Op_Valid=1 and keep o_Opcode/o_Op_CB stable until i_Op_Ready=1.
REQ-029 On VALID with i_Op_Ready=1: SHALL go to ADDR if i_Fetch_En=1 (back-to-back fetch), else to IDLE.
REQ-030 With no waits, o_Op_Valid SHALL be high 3 cycles after i_Fetch_En is sampled in IDLE.
REQ-031 With no waits, back-to-back throughput SHALL be one opcode per 3 cycles.
REQ-032 Deasserting i_Fetch_En mid-fetch SHALL NOT abort the fetch in progress.
REQ-033 o_Read16/o_Write16 SHALL be zero in every state and cycle not named above; o_Write16 bits other than PC_SEL SHALL always be 0.
REQ-034 o_Write16 SHALL never assert in the same cycle as a nonzero o_Read16.
REQ-035 i_Enable=0: state and all latches SHALL hold; o_Mem_Rd and o_Write16 SHALL be forced to 0; o_Op_Valid and o_Opcode SHALL hold; a handshake SHALL NOT complete.

Reset
REQ-036 Asserting i_Reset SHALL immediately force state to IDLE and the address latch, opcode latch and CB flag to 0.
REQ-037 While i_Reset is asserted, all outputs SHALL be 0.
REQ-038 A reset asserted mid-READ SHALL cause no PC write; the PC register value SHALL be untouched by this block.
REQ-039 After i_Reset deasserts, the first fetch SHALL begin only once i_Fetch_En=1 is sampled.

Configuration
REQ-040 The feature macro SHALL be exactly LSHARP_CB_PREFIX_EN.
REQ-041 With LSHARP_CB_PREFIX_EN defined: a first byte equal to CB_PREFIX SHALL set the CB flag and go ADDR->READ again for the second byte (PC incremented twice); VALID SHALL then present the second byte with o_Op_CB=1.
REQ-042 Without LSHARP_CB_PREFIX_EN: 8'hCB SHALL be presented as an ordinary opcode, and o_Op_CB SHALL be tied to 0.

Structure
REQ-043 Package lsharp_pkg SHALL hold the 16-bit register one-hot indices (WZ=0, BC=1, DE=2, HL=3, SP=4, PC=5), the fetch state enum and CB_PREFIX.
REQ-044 One sub-module, lsharp_idu (16-bit increment with wrap), SHALL be instantiated for PC+1.

Verification
REQ-045 PC=16'h0100, memory [0100]=8'h3E, no waits, ready high -> o_Opcode=8'h3E valid on cycle 3; PC write 16'h0101.
REQ-046 PC=16'hFFFF, memory [FFFF]=8'h00 -> o_Bus16=16'h0000 with the PC write strobe.
REQ-047 i_Mem_Wait=1 for 4 cycles -> o_Mem_Addr stable, exactly one PC write, valid on cycle 7.
REQ-048 i_Op_Ready low for 5 cycles in VALID -> opcode stable, no memory reads; ready high with i_Fetch_En=1 -> ADDR the next cycle.
REQ-049 Macro defined, memory [0200]=8'hCB, [0201]=8'h37 -> o_Opcode=8'h37, o_Op_CB=1, PC=16'h0202; macro undefined -> o_Opcode=8'hCB, o_Op_CB=0.
REQ-050 i_Reset pulsed during READ -> outputs 0 immediately, no o_Write16, state IDLE.
